// File: rtl/seg_display_scheduler_pkg.sv
// Shared encodings and small combinational helpers for the seven-segment display scheduler.
package seg_display_scheduler_pkg;

    localparam int         N_REQ      = 3;
    localparam logic [1:0] OWNER_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // First set request searching upward from ptr, wrapping mod N_REQ.
    function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = OWNER_NONE;
        idx  = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == OWNER_NONE && idx != OWNER_NONE && req[idx]) pick = idx;
            idx = rr_next(idx);
        end
        return pick;
    endfunction

    function automatic logic [N_REQ-1:0] owner_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] lz_mask(input logic [15:0] v);
        return {|v[15:12], |v[15:8], |v[15:4], 1'b1};
    endfunction

endpackage

// File: rtl/seg_display_scheduler_counter.sv
// Free-running modulo counter; trig_o is high for the one cycle the count sits at COUNTER_MAX.
module seg_display_scheduler_counter #(
    parameter int          COUNTER_WIDTH = 17,
    parameter int unsigned COUNTER_MAX   = 99999
) (
    input  logic clk,
    input  logic rst,
    output logic trig_o
);

    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] count_d;

    assign trig_o  = (count_q == COUNTER_WIDTH'(COUNTER_MAX));
    assign count_d = trig_o ? '0 : count_q + 1'b1;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin owner arbitration for a shared 4-digit display, with minimum dwell,
// registered one-hot grant, live data tracking and leading-zero blanking.
module seg_display_scheduler
    import seg_display_scheduler_pkg::*;
#(
    parameter int unsigned TICK_MAX   = 99999,
    parameter int unsigned DWELL_MS   = 500,
    parameter logic [15:0] IDLE_VALUE = 16'h0000,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic [15:0]      data0_i,
    input  logic [15:0]      data1_i,
    input  logic [15:0]      data2_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [1:0]       owner_o,
    output logic [3:0]       num0_o,
    output logic [3:0]       num1_o,
    output logic [3:0]       num2_o,
    output logic [3:0]       num3_o,
    output logic [3:0]       digit_en_o,
    output logic             busy_o
);

    localparam int               DWELL_W   = (DWELL_MS > 0) ? $clog2(DWELL_MS + 1) : 1;
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_MS);

    state_e             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [15:0]        num_q, num_d;
    logic [3:0]         en_q, en_d;

    logic        ms_tick;
    logic [1:0]  winner;
    logic [15:0] owner_data;
    logic        owner_holds;
    logic        others_waiting;

    seg_display_scheduler_counter #(
        .COUNTER_WIDTH (17),
        .COUNTER_MAX   (TICK_MAX)
    ) u_ms_tick (
        .clk    (clk),
        .rst    (rst),
        .trig_o (ms_tick)
    );

    assign winner         = rr_pick(req_i, ptr_q);
    assign owner_holds    = |(req_i & gnt_q);
    assign others_waiting = |(req_i & ~gnt_q);

    always_comb begin
        case (owner_q)
            2'd0:    owner_data = data0_i;
            2'd1:    owner_data = data1_i;
            2'd2:    owner_data = data2_i;
            default: owner_data = IDLE_VALUE;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        dwell_d = dwell_q;
        num_d   = num_q;
        en_d    = en_q;

        case (state_q)
            ST_IDLE, ST_SWITCH: begin
                if (state_q == ST_IDLE) begin
                    num_d = IDLE_VALUE;
                    en_d  = 4'b1111;
                end
                if (|req_i) begin
                    state_d = ST_GRANT;
                    owner_d = winner;
                    gnt_d   = owner_onehot(winner);
                    dwell_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRANT: begin
                num_d = owner_data;
                en_d  = BLANK_LZ ? lz_mask(owner_data) : 4'b1111;
                if (ms_tick && dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
                // Release on owner drop, or when dwell is used up and someone else is queued.
                if (!owner_holds || (dwell_q == DWELL_MAX && others_waiting)) begin
                    state_d = ST_SWITCH;
                    owner_d = OWNER_NONE;
                    gnt_d   = '0;
                    ptr_d   = rr_next(owner_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
                owner_d = OWNER_NONE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_NONE;
            ptr_q   <= 2'd0;
            gnt_q   <= '0;
            dwell_q <= '0;
            num_q   <= IDLE_VALUE;
            en_q    <= 4'b1111;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            dwell_q <= dwell_d;
            num_q   <= num_d;
            en_q    <= en_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign owner_o    = owner_q;
    assign busy_o     = |gnt_q;
    assign num0_o     = num_q[3:0];
    assign num1_o     = num_q[7:4];
    assign num2_o     = num_q[11:8];
    assign num3_o     = num_q[15:12];
    assign digit_en_o = en_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed scenarios plus a randomized phase, checked every cycle against a behavioural model.
module tb_seg_display_scheduler;

    localparam int          TICK   = 9;
    localparam int          DWELL  = 4;
    localparam logic [15:0] IDLE_V = 16'h0E05;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] data0, data1, data2;

    logic [2:0]  gnt, gnt_nb;
    logic [1:0]  owner, owner_nb;
    logic [3:0]  n0, n1, n2, n3, n0_nb, n1_nb, n2_nb, n3_nb;
    logic [3:0]  en, en_nb;
    logic        busy, busy_nb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_display_scheduler #(
        .TICK_MAX(TICK), .DWELL_MS(DWELL), .IDLE_VALUE(IDLE_V), .BLANK_LZ(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req),
        .data0_i(data0), .data1_i(data1), .data2_i(data2),
        .gnt_o(gnt), .owner_o(owner),
        .num0_o(n0), .num1_o(n1), .num2_o(n2), .num3_o(n3),
        .digit_en_o(en), .busy_o(busy)
    );

    seg_display_scheduler #(
        .TICK_MAX(TICK), .DWELL_MS(DWELL), .IDLE_VALUE(IDLE_V), .BLANK_LZ(1'b0)
    ) dut_nb (
        .clk(clk), .rst(rst), .req_i(req),
        .data0_i(data0), .data1_i(data1), .data2_i(data2),
        .gnt_o(gnt_nb), .owner_o(owner_nb),
        .num0_o(n0_nb), .num1_o(n1_nb), .num2_o(n2_nb), .num3_o(n3_nb),
        .digit_en_o(en_nb), .busy_o(busy_nb)
    );

    // ---------------- behavioural reference ----------------
    localparam int P_IDLE = 0, P_GRANT = 1, P_SWITCH = 2;
    int          m_phase = P_IDLE;
    int          m_owner = -1;
    int          m_ptr   = 0;
    int          m_held  = 0;
    int          m_tick  = 0;
    logic [15:0] m_num   = IDLE_V;
    logic [3:0]  m_en    = 4'b1111;

    function automatic logic [15:0] data_of(input int o);
        case (o)
            0:       return data0;
            1:       return data1;
            2:       return data2;
            default: return IDLE_V;
        endcase
    endfunction

    function automatic logic [3:0] blank_ref(input logic [15:0] v);
        logic [3:0] e;
        e = 4'b0001;
        for (int i = 1; i < 4; i++) e[i] = ((v >> (4 * i)) != 16'd0);
        return e;
    endfunction

    function automatic int first_from(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= P_IDLE; m_owner <= -1; m_ptr <= 0; m_held <= 0; m_tick <= 0;
            m_num <= IDLE_V; m_en <= 4'b1111;
        end else begin
            automatic bit          tick = (m_tick == TICK);
            automatic logic [15:0] d;
            m_tick <= tick ? 0 : m_tick + 1;
            if (m_phase == P_GRANT) begin
                d = data_of(m_owner);
                m_num  <= d;
                m_en   <= blank_ref(d);
                m_held <= (tick && m_held < DWELL) ? m_held + 1 : m_held;
                if (!req[m_owner] || (m_held == DWELL && (req & ~(3'b001 << m_owner)) != 3'b000)) begin
                    m_phase <= P_SWITCH;
                    m_owner <= -1;
                    m_ptr   <= (m_owner + 1) % 3;
                end
            end else begin
                if (m_phase == P_IDLE) begin
                    m_num <= IDLE_V;
                    m_en  <= 4'b1111;
                end
                if (req != 3'b000) begin
                    m_owner <= first_from(req, m_ptr);
                    m_phase <= P_GRANT;
                    m_held  <= 0;
                end else begin
                    m_phase <= P_IDLE;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            logic [2:0] eg;
            @(negedge clk);
            eg = (m_owner < 0) ? 3'b000 : 3'(3'b001 << m_owner);
            check("gnt",      32'(gnt),   32'(eg));
            check("owner",    32'(owner), (m_owner < 0) ? 32'd3 : 32'(m_owner));
            check("busy",     32'(busy),  32'(eg != 3'b000));
            check("num",      32'({n3, n2, n1, n0}), 32'(m_num));
            check("digit_en", 32'(en),    32'(m_en));
            check("nb_gnt",   32'(gnt_nb), 32'(eg));
            check("nb_en",    32'(en_nb),  32'hF);
        end
    endtask

    task automatic wait_gnt(input bit want_busy, input string tag);
        int n = 0;
        while (((gnt != 3'b000) != want_busy) && n < 200) begin
            step(1);
            n++;
        end
        check(tag, 32'(n < 200), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int order[4] = '{0, 1, 2, 0};
        rst = 1'b1; req = 3'b000;
        data0 = 16'h1234; data1 = 16'h0000; data2 = 16'h0BCD;
        step(2);
        check("rst_gnt",   32'(gnt),   32'd0);
        check("rst_owner", 32'(owner), 32'd3);
        check("rst_num",   32'({n3, n2, n1, n0}), 32'(IDLE_V));
        check("rst_en",    32'(en),    32'hF);
        rst = 1'b0;
        step(2);

        // Single requester, 1-cycle grant latency, 1 more cycle for data
        req = 3'b010; data1 = 16'h00A3;
        step(1);
        check("first_gnt",   32'(gnt),   32'b010);
        check("first_owner", 32'(owner), 32'd1);
        step(1);
        check("first_num", 32'({n3, n2, n1, n0}), 32'h00A3);
        check("first_en",  32'(en), 32'b0011);
        step(3);
        req = 3'b011;
        wait_gnt(1'b0, "dwell_release_timeout");
        check("switch_owner", 32'(owner), 32'd3);
        step(1);
        check("handover_gnt", 32'(gnt), 32'b001);
        req = 3'b000;
        step(3);

        // Fresh pointer, all three requesting: 0,1,2,0 with single gap cycles
        rst = 1'b1; step(1); rst = 1'b0;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(1'b1, "rr_grant_timeout");
            check("rr_order", 32'(gnt), 32'(3'b001 << order[i]));
            if (i < 3) begin
                wait_gnt(1'b0, "rr_gap_timeout");
                step(1);
                check("rr_gap_one_cycle", 32'(busy), 32'd1);
            end
        end

        // Owner 2 releases early, then nobody requests
        req = 3'b100;
        wait_gnt(1'b0, "drop0_timeout");
        step(1);
        check("owner2_gnt", 32'(gnt), 32'b100);
        step(2);
        req = 3'b000;
        step(1);
        check("early_release_gnt", 32'(gnt), 32'd0);
        step(2);
        check("idle_num", 32'({n3, n2, n1, n0}), 32'(IDLE_V));
        check("idle_en",  32'(en), 32'hF);

        // Blanking of an all-zero value
        data0 = 16'h0000; req = 3'b001;
        step(2);
        check("zero_gnt",    32'(gnt),   32'b001);
        check("zero_en",     32'(en),    32'b0001);
        check("zero_en_nb",  32'(en_nb), 32'hF);

        // Asynchronous reset during a grant
        #2 rst = 1'b1;
        #1;
        check("async_gnt",   32'(gnt),   32'd0);
        check("async_owner", 32'(owner), 32'd3);
        check("async_busy",  32'(busy),  32'd0);
        step(1);
        rst = 1'b0; req = 3'b100;
        step(1);
        check("post_reset_gnt", 32'(gnt), 32'b100);

        // Randomized phase
        for (int c = 0; c < 1500; c++) begin
            logic [15:0] masks[4] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000};
            step(1);
            if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
            data0 = 16'($urandom) & masks[$urandom_range(0, 3)];
            data1 = 16'($urandom) & masks[$urandom_range(0, 3)];
            data2 = 16'($urandom) & masks[$urandom_range(0, 3)];
        end
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
